// File: rtl/oam_scan.sv
// oam_scan: 160-byte object attribute memory with DMA and CPU ports, plus a
// per-line object search that captures up to MAX_OBJ matching entries in
// ascending OAM order. Each entry takes two cycles (Y, then X/tile/attr),
// so a full scan takes a fixed 2*NUM_ENTRIES cycles.
module oam_scan #(
    parameter int MAX_OBJ     = 10,
    parameter int NUM_ENTRIES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_wr,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_occupy_oambus,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_a,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic        scan_start,
    input  logic [7:0]  scan_ly,
    input  logic        obj_size,
    output logic        scan_busy,
    output logic        scan_done,
    output logic [3:0]  obj_count,
    input  logic [3:0]  obj_idx,
    output logic [31:0] obj_entry,
    output logic [1:0]  dbg_state
);

    localparam int          BYTES   = NUM_ENTRIES * 4;
    localparam int          IDXW    = $clog2(NUM_ENTRIES);
    localparam logic [8:0]  LIMIT   = 9'(BYTES);
    localparam logic [3:0]  MAX_CNT = 4'(MAX_OBJ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READ_Y    = 2'd1,
        S_READ_REST = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    // Byte n is entry n/4, field n%4 in the order Y, X, tile, attr.
    logic [7:0] mem [0:BYTES-1];

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [7:0]        ly_q, ly_d;
    logic              size_q, size_d;
    logic [7:0]        y_q, y_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       res_q [MAX_OBJ];
    logic [31:0]       res_d [MAX_OBJ];
    logic [7:0]        cpu_dout_q, cpu_dout_d;

    logic        dma_hit;
    logic        cpu_in_range;
    logic        cpu_hit;
    logic [7:0]  base;
    logic [31:0] entry_w;
    logic [8:0]  line9;
    logic [8:0]  y9;
    logic [8:0]  h9;
    logic        match;

    // DMA always wins the port; the CPU only writes when the bus is free,
    // no scan is running and DMA is not strobing in the same cycle.
    assign dma_hit      = dma_wr && (dma_a[15:8] == 8'hFE) && ({1'b0, dma_a[7:0]} < LIMIT);
    assign cpu_in_range = ({1'b0, cpu_a} < LIMIT);
    assign cpu_hit      = cpu_wr && !dma_wr && cpu_in_range && !dma_occupy_oambus && !busy_q;

    // Entry currently being examined and its match test. Arithmetic is done
    // in 9 bits so Y near 255 cannot wrap into a false match.
    assign base    = 8'({idx_q, 2'b00});
    assign entry_w = {y_q, mem[base + 8'd1], mem[base + 8'd2], mem[base + 8'd3]};
    assign line9   = {1'b0, ly_q} + 9'd16;
    assign y9      = {1'b0, y_q};
    assign h9      = size_q ? 9'd16 : 9'd8;
    assign match   = (y9 <= line9) && (line9 < (y9 + h9));

    // Storage write port; not reset, contents are undefined until written.
    always_ff @(posedge clk) begin
        if (dma_hit) begin
            mem[dma_a[7:0]] <= dma_wdata;
        end else if (cpu_hit) begin
            mem[cpu_a] <= cpu_din;
        end
    end

    // CPU read data: captured on cpu_rd, held otherwise; reads see the old byte.
    always_comb begin
        cpu_dout_d = cpu_dout_q;
        if (cpu_rd) begin
            if (dma_occupy_oambus || busy_q) begin
                cpu_dout_d = 8'hFF;
            end else if (!cpu_in_range) begin
                cpu_dout_d = 8'h00;
            end else begin
                cpu_dout_d = mem[cpu_a];
            end
        end
    end

    // Register the CPU read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_dout_q <= 8'h00;
        end else begin
            cpu_dout_q <= cpu_dout_d;
        end
    end

    // Scan sequencer next-state: two cycles per entry, matches appended in order.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ly_d    = ly_q;
        size_d  = size_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    state_d = S_READ_Y;
                    ly_d    = scan_ly;
                    size_d  = obj_size;
                    idx_d   = '0;
                    cnt_d   = 4'd0;
                end
            end
            S_READ_Y: begin
                y_d     = mem[base];
                state_d = S_READ_REST;
            end
            S_READ_REST: begin
                // Matches beyond MAX_OBJ are dropped but the scan keeps going.
                if (match && (cnt_q < MAX_CNT)) begin
                    res_d[cnt_q] = entry_w;
                    cnt_d        = cnt_q + 4'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_READ_Y;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_READ_Y) || (state_d == S_READ_REST);
        done_d = (state_d == S_DONE);
    end

    // Scan sequencer state and registered outputs; reset aborts any scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ly_q    <= 8'h00;
            size_q  <= 1'b0;
            y_q     <= 8'h00;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < MAX_OBJ; i++) begin
                res_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ly_q    <= ly_d;
            size_q  <= size_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign cpu_dout  = cpu_dout_q;
    assign scan_busy = busy_q;
    assign scan_done = done_q;
    assign obj_count = cnt_q;
    assign obj_entry = (obj_idx < cnt_q) ? res_q[obj_idx] : 32'h0;
    assign dbg_state = state_q;

endmodule

// File: doc/oam_scan.md
OAM_SCAN -- requirements
Module: oam_scan

Interface
REQ-001 Parameter MAX_OBJ, default 10: maximum objects captured per scan.
REQ-002 Parameter NUM_ENTRIES, default 40: OAM entries of 4 bytes each (160 bytes).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 dma_wr  in  1  DMA write strobe, level, sampled every clk.
REQ-007 dma_a  in  16  DMA write address.
REQ-008 dma_wdata  in  8  DMA write data.
REQ-009 dma_occupy_oambus  in  1  DMA owns the OAM bus.
REQ-010 cpu_rd  in  1  CPU read strobe.
REQ-011 cpu_wr  in  1  CPU write strobe.
REQ-012 cpu_a  in  8  CPU offset within page FE.
REQ-013 cpu_din  in  8  CPU write data.
REQ-014 cpu_dout  out  8  CPU read data, registered.
REQ-015 scan_start  in  1  one-cycle pulse that starts an object search.
REQ-016 scan_ly  in  8  current line, sampled on scan_start.
REQ-017 obj_size  in  1  0 = 8-line objects, 1 = 16-line objects, sampled on scan_start.
REQ-018 scan_busy  out  1  search in progress.
REQ-019 scan_done  out  1  one-cycle pulse at the end of a search.
REQ-020 obj_count  out  4  number of objects captured.
REQ-021 obj_idx  in  4  result-buffer read index.
REQ-022 obj_entry  out  32  captured entry {Y,X,tile,attr}, combinational from obj_idx; 0 if obj_idx >= obj_count.

Function
REQ-023 Storage SHALL be 160 bytes; byte n is entry n/4 and field n%4, in the order Y, X, tile, attr.
REQ-024 DMA write: dma_wr=1, dma_a[15:8]=8'hFE and dma_a[7:0]<8'hA0 SHALL write dma_wdata on that edge; all other dma_wr cycles are ignored.
REQ-025 DMA writes SHALL proceed regardless of scan_busy or dma_occupy_oambus.
REQ-026 CPU write: takes effect only when cpu_a<8'hA0, dma_occupy_oambus=0 and scan_busy=0; otherwise it is dropped.
REQ-027 If dma_wr and cpu_wr are active in the same cycle, the DMA write SHALL win and the CPU write is dropped.
REQ-028 CPU read: on an edge with cpu_rd=1, cpu_dout SHALL load one of the following, then hold until the next cpu_rd.
  - 8'hFF if dma_occupy_oambus or scan_busy;
  - otherwise 8'h00 if cpu_a>=8'hA0;
  - otherwise the stored byte.
REQ-029 Read-during-write to the same byte SHALL return the old value.
REQ-030 The scan state machine SHALL have the states IDLE, READ_Y, READ_REST and DONE.
REQ-031 IDLE -> READ_Y when scan_start=1; on that edge the block SHALL latch scan_ly and obj_size, and clear the entry index and obj_count.
REQ-032 scan_start SHALL be ignored in any state other than IDLE.
REQ-033 READ_Y: the Y byte of the current entry SHALL be registered; next state is READ_REST.
REQ-034 READ_REST: X, tile and attr SHALL be read and the entry tested.
  - Match rule: Y <= ly+16 < Y+H, with H = 8 or 16, evaluated with 9-bit unsigned arithmetic (no wrap).
  - On a match with obj_count<MAX_OBJ, the entry SHALL be appended to the buffer and obj_count incremented.
  - Next state: READ_Y with index+1, or DONE when index = NUM_ENTRIES-1.
REQ-035 The scan SHALL run through all 40 entries even after MAX_OBJ objects are captured; further matches are discarded.
REQ-036 The scan SHALL take a fixed 80 cycles, READ_Y through READ_REST.
REQ-037 scan_busy SHALL be 1 in READ_Y and READ_REST.
REQ-038 DONE: scan_done=1 for one cycle, then the state returns to IDLE.
REQ-039 obj_count and the buffer SHALL hold until the next scan_start.
REQ-040 Captured entries SHALL appear in ascending OAM index order.
REQ-041 A DMA write during a scan SHALL be visible to entries read after it; no atomicity is guaranteed.

Reset
REQ-042 On rst the block SHALL set the following: state IDLE, scan_busy 0, scan_done 0, obj_count 0, cpu_dout 8'h00, entry index 0.
REQ-043 The result buffer SHALL be cleared by reset.
REQ-044 OAM storage is NOT reset; its contents are unspecified until written.
REQ-045 rst asserted mid-scan SHALL abort the scan immediately with no scan_done pulse.

Verification
REQ-046 DMA fill: dma_wr for FE00..FE9F with data = low address byte, then CPU reads FE00, FE53 and FE9F -> 8'h00, 8'h53, 8'h9F.
REQ-047 Blocking:
  - with dma_occupy_oambus=1, a CPU write of 8'h5A to offset 8'h10, then a read -> 8'hFF;
  - after deassert, the read returns the DMA-written value;
  - a read of cpu_a=8'hC0 -> 8'h00.
REQ-048 Scan, 8-line objects: entries 3, 7 and 20 have Y=16 and all others Y=0; scan_ly=0.
  - obj_count=3 and scan_done exactly 81 cycles after scan_start (inclusive);
  - obj_entry(0) = entry 3.
REQ-049 Overflow: all 40 entries Y=20, obj_size=1, scan_ly=10 -> obj_count=10, entries 0..9 captured, duration still 80 cycles.
REQ-050 Boundary, obj_size=0, Y=8'h10:
  - scan_ly=7 matches;
  - scan_ly=8 does not match;
  - Y=8'hFF with scan_ly=8'hFF does not falsely match through wrap.
REQ-051 Control corner cases:
  - rst at cycle 40 of a scan -> scan_busy=0, obj_count=0, no scan_done;
  - a second scan_start while busy has no effect on duration or results.
